ramb4_s2_s8_fifo_ctl: RTL and testbench

RAMB4_S2_S8_FIFO_CTL -- requirements
Module: ramb4_s2_s8_fifo_ctl

---
 rtl/ramb4_s2_s8_fifo_ctl.sv | 144 ++++++++++++++
 tb/tb_ramb4_s2_s8_fifo_ctl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ramb4_s2_s8_fifo_ctl.sv
// ramb4_s2_s8_fifo_ctl
// FIFO controller around a dual-port RAMB4 used as 2048 x 2-bit (port A, write)
// and 512 x 8-bit (port B, read). Symbols go in two bits at a time and come out
// as whole bytes, with the oldest symbol in rd_data[1:0].
//
// Ports
//   CLKA, RSTB             : clock (rising edge), synchronous active-high reset
//   wr_valid/wr_data/wr_ready : 2-bit symbol write handshake
//   rd_valid/rd_data/rd_ready : 8-bit byte read handshake
//   level, afull, aempty   : stored symbol count and threshold flags
//   ram_addra/dia/ena/wea  : RAM write port (2-bit side)
//   ram_addrb/enb, ram_dob : RAM read port (8-bit side), dob registered in RAM
//   ram_rsta/rstb/web      : tied low
module ramb4_s2_s8_fifo_ctl #(
    parameter logic [11:0] AFULL_LVL  = 12'd1792,
    parameter logic [9:0]  AEMPTY_LVL = 10'd1
) (
    input  logic        CLKA,
    input  logic        RSTB,
    input  logic        wr_valid,
    input  logic [1:0]  wr_data,
    output logic        wr_ready,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    input  logic        rd_ready,
    output logic [11:0] level,
    output logic        afull,
    output logic        aempty,
    output logic [10:0] ram_addra,
    output logic [1:0]  ram_dia,
    output logic        ram_ena,
    output logic        ram_wea,
    output logic [8:0]  ram_addrb,
    output logic        ram_enb,
    input  logic [7:0]  ram_dob,
    output logic        ram_rsta,
    output logic        ram_rstb,
    output logic        ram_web
);

    localparam int unsigned SYM_PTR_W  = 12;
    localparam int unsigned BYTE_PTR_W = 10;
    localparam logic [SYM_PTR_W-1:0] FULL_LVL = SYM_PTR_W'(2048);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        CAPT  = 2'd2,
        VALID = 2'd3
    } rd_state_t;

    rd_state_t              r_state;
    rd_state_t              w_nxt_state;
    logic [SYM_PTR_W-1:0]   r_wptr;
    logic [BYTE_PTR_W-1:0]  r_rptr;
    logic                   r_rd_valid;
    logic [7:0]             r_rd_data;
    logic                   w_nxt_rd_valid;
    logic [7:0]             w_nxt_rd_data;
    logic                   w_fetch;
    logic                   w_wr_ready;
    logic                   w_wr_acc;
    logic [SYM_PTR_W-1:0]   w_level;
    logic [BYTE_PTR_W-1:0]  w_avail;

    // Occupancy: the read pointer counts bytes, so scale it to symbols.
    assign w_level    = r_wptr - {r_rptr, 2'b00};
    assign w_avail    = r_wptr[SYM_PTR_W-1:2] - r_rptr;
    assign w_wr_ready = (w_level < FULL_LVL);
    // No RAM activity at all in a reset cycle.
    assign w_wr_acc   = wr_valid & w_wr_ready & ~RSTB;

    assign wr_ready  = w_wr_ready;
    assign level     = w_level;
    assign afull     = (w_level >= AFULL_LVL);
    assign aempty    = (w_avail <= AEMPTY_LVL);

    assign ram_ena   = w_wr_acc;
    assign ram_wea   = w_wr_acc;
    assign ram_addra = r_wptr[10:0];
    assign ram_dia   = wr_data;
    assign ram_enb   = w_fetch & ~RSTB;
    assign ram_addrb = r_rptr[8:0];
    assign ram_rsta  = 1'b0;
    assign ram_rstb  = 1'b0;
    assign ram_web   = 1'b0;

    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;

    // Read FSM next-state and output-register inputs.
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_rd_valid = r_rd_valid;
        w_nxt_rd_data  = r_rd_data;
        w_fetch        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_avail != '0) begin
                    w_nxt_state = FETCH;
                end
            end
            FETCH: begin
                w_fetch     = 1'b1;
                w_nxt_state = CAPT;
            end
            CAPT: begin
                w_nxt_rd_data  = ram_dob;
                w_nxt_rd_valid = 1'b1;
                w_nxt_state    = VALID;
            end
            VALID: begin
                if (rd_ready) begin
                    w_nxt_rd_valid = 1'b0;
                    // rptr already moved past the held byte, so w_avail counts only unread bytes.
                    w_nxt_state    = (w_avail != '0) ? FETCH : IDLE;
                end
            end
        endcase
    end

    // State, pointers and output registers.
    always_ff @(posedge CLKA) begin
        if (RSTB) begin
            r_state    <= IDLE;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= 8'h00;
        end else begin
            r_state    <= w_nxt_state;
            r_rd_valid <= w_nxt_rd_valid;
            r_rd_data  <= w_nxt_rd_data;
            if (w_wr_acc) begin
                r_wptr <= r_wptr + SYM_PTR_W'(1);
            end
            // Space is released at the RAM read edge itself.
            if (w_fetch) begin
                r_rptr <= r_rptr + BYTE_PTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ramb4_s2_s8_fifo_ctl.sv
// Bench for ramb4_s2_s8_fifo_ctl: behavioural RAMB4 model, occupancy model and
// byte scoreboard, with one task per scenario.
module tb_ramb4_s2_s8_fifo_ctl;

    logic        CLKA = 1'b0;
    logic        RSTB, wr_valid, wr_ready, rd_valid, rd_ready;
    logic [1:0]  wr_data;
    logic [7:0]  rd_data;
    logic [11:0] level;
    logic        afull, aempty;
    logic [10:0] ram_addra;
    logic [1:0]  ram_dia;
    logic        ram_ena, ram_wea, ram_enb;
    logic [8:0]  ram_addrb;
    logic [7:0]  ram_dob;
    logic        ram_rsta, ram_rstb, ram_web;

    always #5 CLKA = ~CLKA;

    ramb4_s2_s8_fifo_ctl dut (
        .CLKA(CLKA), .RSTB(RSTB),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .level(level), .afull(afull), .aempty(aempty),
        .ram_addra(ram_addra), .ram_dia(ram_dia), .ram_ena(ram_ena), .ram_wea(ram_wea),
        .ram_addrb(ram_addrb), .ram_enb(ram_enb), .ram_dob(ram_dob),
        .ram_rsta(ram_rsta), .ram_rstb(ram_rstb), .ram_web(ram_web)
    );

    // RAMB4_S2_S8 model: 2-bit write port, 8-bit registered read port.
    logic [1:0] mem [0:2047];
    always @(posedge CLKA) begin
        if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
        if (ram_enb) ram_dob <= {mem[{ram_addrb, 2'd3}], mem[{ram_addrb, 2'd2}],
                                 mem[{ram_addrb, 2'd1}], mem[{ram_addrb, 2'd0}]};
    end

    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [7:0]  exp_q[$];
    int          m_level = 0;
    logic [11:0] m_wptr = '0;
    logic [9:0]  m_rptr = '0;
    logic [7:0]  asm_byte = '0;
    int          asm_n = 0;
    logic        chk_en = 1'b0;
    int          enb_cnt = 0, rdv_cnt = 0, got_bytes = 0, gen_cnt = 0;
    logic        s_rdv, s_enb, s_acc;
    logic [7:0]  s_rdd;

    function automatic logic [1:0] gen_sym(input int n);
        logic [7:0] b;
        b = 8'(n / 4);
        return b[2*(n % 4) +: 2];
    endfunction

    // One clock: drive, sample at negedge against the models, advance models.
    task automatic step(input logic rst, input logic wv, input logic [1:0] wd, input logic rr);
        logic acc, fetch;
        logic [16:0] exp_st, got_st;
        logic [7:0] eb;
        RSTB = rst; wr_valid = wv; wr_data = wd; rd_ready = rr;
        @(negedge CLKA);
        acc   = wv && !rst && (m_level < 2048);
        fetch = ram_enb;
        s_rdv = rd_valid; s_rdd = rd_data; s_enb = ram_enb; s_acc = acc;
        if (ram_enb) enb_cnt++;
        if (rd_valid) rdv_cnt++;
        if (chk_en) begin
            exp_st = {12'(m_level), m_level < 2048, m_level >= 1792, (m_level / 4) <= 1, acc, acc};
            got_st = {level, wr_ready, afull, aempty, ram_ena, ram_wea};
            total_cnt++;
            if (got_st !== exp_st) $display("FAIL cycle_status got %h exp %h (level/wr_ready/afull/aempty/ena/wea)", got_st, exp_st);
            else pass_cnt++;
            total_cnt++;
            if (ram_enb && (rst || m_level < 4)) $display("FAIL read_enable got enb=1 exp 0 (level=%0d rst=%0b)", m_level, rst);
            else pass_cnt++;
            if (acc) begin
                total_cnt++;
                if ({ram_addra, ram_dia} !== {m_wptr[10:0], wd}) $display("FAIL write_port got %h/%h exp %h/%h", ram_addra, ram_dia, m_wptr[10:0], wd);
                else pass_cnt++;
            end
            if (fetch) begin
                total_cnt++;
                if (ram_addrb !== m_rptr[8:0]) $display("FAIL read_addr got %h exp %h", ram_addrb, m_rptr[8:0]);
                else pass_cnt++;
            end
            if (rd_valid && rr && !rst) begin
                total_cnt++;
                if (exp_q.size() == 0) $display("FAIL scoreboard got byte %h exp none", rd_data);
                else begin
                    eb = exp_q.pop_front();
                    got_bytes++;
                    if (rd_data !== eb) $display("FAIL scoreboard got %h exp %h", rd_data, eb);
                    else pass_cnt++;
                end
            end
        end
        if (rst) begin
            m_level = 0; m_wptr = '0; m_rptr = '0; asm_n = 0; exp_q.delete(); chk_en = 1'b1;
        end else begin
            if (acc) begin
                asm_byte[2*asm_n +: 2] = wd;
                asm_n++;
                if (asm_n == 4) begin exp_q.push_back(asm_byte); asm_n = 0; end
                m_wptr = m_wptr + 12'd1;
                m_level++;
            end
            if (fetch) begin
                m_rptr = m_rptr + 10'd1;
                m_level -= 4;
            end
        end
        @(posedge CLKA);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 2'd0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 1'b0);
        total_cnt++;
        if ({level, wr_ready, afull, aempty} !== {12'd0, 1'b1, 1'b0, 1'b1}) $display("FAIL reset_flags got %h/%b%b%b exp 000/101", level, wr_ready, afull, aempty);
        else pass_cnt++;
        total_cnt++;
        if ({rd_valid, rd_data} !== 9'h000) $display("FAIL reset_rd got %b/%h exp 0/00", rd_valid, rd_data);
        else pass_cnt++;
        total_cnt++;
        if ({ram_rsta, ram_rstb, ram_web, ram_ena, ram_enb} !== 5'b0) $display("FAIL reset_ram_ctl got %b exp 00000", {ram_rsta, ram_rstb, ram_web, ram_ena, ram_enb});
        else pass_cnt++;
    endtask

    task automatic test_single_byte();
        logic [1:0] syms [4];
        syms = '{2'd1, 2'd2, 2'd3, 2'd0};
        step(1'b1, 1'b0, 2'd0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, syms[i], 1'b1);
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 1'b0, 2'd0, 1'b1);
            total_cnt++;
            if (k < 4 && s_rdv !== 1'b0) $display("FAIL latency_early cycle N+%0d got rd_valid=%b exp 0", k, s_rdv);
            else if (k == 4 && {s_rdv, s_rdd} !== {1'b1, 8'h39}) $display("FAIL latency_byte got %b/%h exp 1/39", s_rdv, s_rdd);
            else pass_cnt++;
        end
        step(1'b0, 1'b0, 2'd0, 1'b1);
        total_cnt++;
        if ({level, rd_valid} !== {12'd0, 1'b0} || exp_q.size() != 0) $display("FAIL single_drain got level=%0d rd_valid=%b queued=%0d exp 0/0/0", level, rd_valid, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_partial();
        step(1'b1, 1'b0, 2'd0, 1'b1);
        enb_cnt = 0; rdv_cnt = 0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'd3, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 2'd0, 1'b1);
        total_cnt++;
        if (enb_cnt != 0 || rdv_cnt != 0) $display("FAIL partial_read got enb=%0d rdv=%0d cycles exp 0/0", enb_cnt, rdv_cnt);
        else pass_cnt++;
        total_cnt++;
        if (level !== 12'd3) $display("FAIL partial_level got %0d exp 3", level);
        else pass_cnt++;
    endtask

    task automatic test_fill();
        int afull_lvl;
        afull_lvl = -1;
        step(1'b1, 1'b0, 2'd0, 1'b0);
        gen_cnt = 0; got_bytes = 0;
        for (int i = 0; i < 2100 && m_level < 2048; i++) begin
            if (afull && afull_lvl < 0) afull_lvl = int'(level);
            step(1'b0, 1'b1, gen_sym(gen_cnt), 1'b0);
            if (s_acc) gen_cnt++;
        end
        total_cnt++;
        if ({level, wr_ready} !== {12'd2048, 1'b0}) $display("FAIL full_state got level=%0d wr_ready=%b exp 2048/0", level, wr_ready);
        else pass_cnt++;
        total_cnt++;
        if (gen_cnt != 2052) $display("FAIL full_count got %0d exp 2052 symbols accepted", gen_cnt);
        else pass_cnt++;
        total_cnt++;
        if (afull_lvl != 1792) $display("FAIL afull_threshold got %0d exp 1792", afull_lvl);
        else pass_cnt++;
        step(1'b0, 1'b1, gen_sym(gen_cnt), 1'b0);
        total_cnt++;
        if (level !== 12'd2048 || s_acc) $display("FAIL full_ignore got level=%0d exp 2048", level);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        int start, cyc;
        start = gen_cnt; cyc = 0;
        while (gen_cnt - start < 5000 && cyc < 20000) begin
            step(1'b0, 1'b1, gen_sym(gen_cnt), 1'b1);
            if (s_acc) gen_cnt++;
            cyc++;
        end
        cyc = 0;
        while ((exp_q.size() != 0 || level != 12'd0) && cyc < 10000) begin
            step(1'b0, 1'b0, 2'd0, 1'b1);
            cyc++;
        end
        total_cnt++;
        if (gen_cnt - start != 5000) $display("FAIL stream_written got %0d exp 5000", gen_cnt - start);
        else pass_cnt++;
        total_cnt++;
        if (got_bytes != 1763 || exp_q.size() != 0) $display("FAIL stream_bytes got %0d (left %0d) exp 1763 (left 0)", got_bytes, exp_q.size());
        else pass_cnt++;
        total_cnt++;
        if (level !== 12'd0) $display("FAIL stream_empty got level=%0d exp 0", level);
        else pass_cnt++;
    endtask

    task automatic test_reset_in_capt();
        logic [1:0] syms [4];
        logic seen;
        syms = '{2'd1, 2'd2, 2'd3, 2'd0};
        step(1'b1, 1'b0, 2'd0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, syms[i], 1'b1);
        step(1'b0, 1'b0, 2'd0, 1'b1);
        step(1'b0, 1'b0, 2'd0, 1'b1);
        total_cnt++;
        if (s_enb !== 1'b1) $display("FAIL capt_fetch got enb=%b exp 1", s_enb);
        else pass_cnt++;
        step(1'b1, 1'b1, 2'd2, 1'b1);
        total_cnt++;
        if ({rd_valid, level, wr_ready} !== {1'b0, 12'd0, 1'b1}) $display("FAIL capt_reset got %b/%0d/%b exp 0/0/1", rd_valid, level, wr_ready);
        else pass_cnt++;
        syms = '{2'd2, 2'd1, 2'd0, 2'd3};
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, syms[i], 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(1'b0, 1'b0, 2'd0, 1'b1);
            if (s_rdv) begin
                seen = 1'b1;
                total_cnt++;
                if (s_rdd !== 8'hC6) $display("FAIL capt_reread got %h exp c6", s_rdd);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (!seen) $display("FAIL capt_timeout got no rd_valid exp byte c6");
        else pass_cnt++;
    endtask

    task automatic test_back_pressure();
        logic [7:0] hold;
        int cyc;
        step(1'b1, 1'b0, 2'd0, 1'b0);
        gen_cnt = 0;
        for (int i = 0; i < 4; i++) begin step(1'b0, 1'b1, gen_sym(gen_cnt), 1'b0); gen_cnt++; end
        cyc = 0;
        while (!rd_valid && cyc < 10) begin step(1'b0, 1'b0, 2'd0, 1'b0); cyc++; end
        total_cnt++;
        if (!rd_valid) $display("FAIL bp_timeout got rd_valid=0 exp 1");
        else pass_cnt++;
        hold = rd_data;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, gen_sym(gen_cnt), 1'b0);
            if (s_acc) gen_cnt++;
            total_cnt++;
            if ({s_rdv, s_enb, s_rdd} !== {1'b1, 1'b0, hold}) $display("FAIL bp_hold got %b/%b/%h exp 1/0/%h", s_rdv, s_enb, s_rdd, hold);
            else pass_cnt++;
        end
        while (gen_cnt % 4 != 0) begin step(1'b0, 1'b1, gen_sym(gen_cnt), 1'b1); if (s_acc) gen_cnt++; end
        cyc = 0;
        while ((exp_q.size() != 0 || level != 12'd0) && cyc < 100) begin step(1'b0, 1'b0, 2'd0, 1'b1); cyc++; end
        total_cnt++;
        if (exp_q.size() != 0 || level !== 12'd0) $display("FAIL bp_drain got left=%0d level=%0d exp 0/0", exp_q.size(), level);
        else pass_cnt++;
    endtask

    initial begin
        RSTB = 1'b1; wr_valid = 1'b0; wr_data = 2'd0; rd_ready = 1'b0;
        test_reset();
        test_single_byte();
        test_partial();
        test_fill();
        test_stream();
        test_reset_in_capt();
        test_back_pressure();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
